// File: rtl/pixclk_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixclk_gen_pkg
// Description : Shared types, constants and helpers for the pixclk_gen
//               clock-enable generator (channel-select width, lock counter
//               width, divide-by-two increment).
// Revision    : 1.0 - initial release
// ============================================================================
package pixclk_gen_pkg;

    // Width of the per-channel saturating lock counter
    localparam int LOCK_CNT_W = 8;

    // Increment giving a divide-by-two enable; stored as a 48-bit value with
    // the set bit at position 47 so it can be right-aligned to any ACC_W
    localparam logic [47:0] DIV2_INC = 48'h8000_0000_0000;

    // Channel-select width: at least one bit even for a single channel
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixclk_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pixclk_gen_if
// Description : Configuration bus for pixclk_gen: increment write strobe,
//               target channel, new increment and global phase-align request.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixclk_gen_if
    import pixclk_gen_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int ACC_W = 32
);
    localparam int CH_W = ch_w(N_CH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic             sync_req;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_inc,
        output sync_req
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_inc,
        input sync_req
    );

endinterface
`default_nettype wire

// File: rtl/pixclk_gen_ch.sv
`default_nettype none
// ============================================================================
// Module      : pixclk_gen_ch
// Description : One fractional phase-accumulator channel: increment register,
//               accumulator, carry-driven clock-enable strobe and a
//               saturating lock counter. With PIXCLK_GEN_SQUARE_OUT_EN
//               defined, also a registered copy of the accumulator MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module pixclk_gen_ch
    import pixclk_gen_pkg::*;
#(
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(DIV2_INC >> (48 - ACC_W)),
    parameter int               LOCK_PULSES = 16
) (
    input  wire logic             refclk,
    input  wire logic             rst_n,
    input  wire logic             i_cfg_hit,
    input  wire logic [ACC_W-1:0] i_cfg_inc,
    input  wire logic             i_sync,
    output logic                  o_ce,
    output logic                  o_locked
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
    ,
    output logic                  o_sq
`endif
);

    localparam logic [LOCK_CNT_W-1:0] c_LOCK_MAX = LOCK_CNT_W'(LOCK_PULSES);

    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      r_inc;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic                  r_ce;
    logic                  r_locked;

    logic [ACC_W:0]        w_sum;
    logic                  w_carry;
    logic [ACC_W-1:0]      w_acc_nxt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;

    // Next accumulator / carry; a sync request discards the carry of this edge,
    // and a reconfiguration restarts the lock count even if a carry occurs
    always_comb begin
        w_sum          = {1'b0, r_acc} + {1'b0, r_inc};
        w_carry        = w_sum[ACC_W] & ~i_sync;
        w_acc_nxt      = i_sync ? '0 : w_sum[ACC_W-1:0];
        w_lock_cnt_nxt = r_lock_cnt;
        if (i_cfg_hit) begin
            w_lock_cnt_nxt = '0;
        end else if (w_carry && (r_lock_cnt != c_LOCK_MAX)) begin
            w_lock_cnt_nxt = r_lock_cnt + LOCK_CNT_W'(1);
        end
    end

    // Channel state; the new increment is only used from the following edge
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_inc      <= DEFAULT_INC;
            r_lock_cnt <= '0;
            r_ce       <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_ce       <= w_carry;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (w_lock_cnt_nxt == c_LOCK_MAX);
            if (i_cfg_hit) begin
                r_inc <= i_cfg_inc;
            end
        end
    end

    assign o_ce     = r_ce;
    assign o_locked = r_locked;

`ifdef PIXCLK_GEN_SQUARE_OUT_EN
    logic             r_sq;
    logic [ACC_W-1:0] w_inc_nxt;

    assign w_inc_nxt = i_cfg_hit ? i_cfg_inc : r_inc;

    // Square wave follows the accumulator MSB, held low for an idle channel
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= 1'b0;
        end else begin
            r_sq <= (w_inc_nxt != '0) & w_acc_nxt[ACC_W-1];
        end
    end

    assign o_sq = r_sq;
`else
    // No square-wave register in this build
`endif

endmodule
`default_nettype wire

// File: rtl/pixclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : pixclk_gen
// Description : Multi-channel programmable clock-enable generator. N_CH
//               phase-accumulator channels run from refclk, each giving a
//               single-cycle ce strobe at refclk * inc / 2^ACC_W and a lock
//               flag after LOCK_PULSES strobes. Channels are reprogrammed
//               through the cfg bus and phase-aligned with sync_req.
//               Optional macro PIXCLK_GEN_SQUARE_OUT_EN adds sq_out.
// Revision    : 1.0 - initial release
// ============================================================================
module pixclk_gen
    import pixclk_gen_pkg::*;
#(
    parameter int               N_CH        = 2,
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(DIV2_INC >> (48 - ACC_W)),
    parameter int               LOCK_PULSES = 16
) (
    input  wire logic      refclk,
    input  wire logic      rst_n,
    pixclk_gen_if.slave    cfg,
    output logic [N_CH-1:0] ce,
    output logic [N_CH-1:0] locked
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
    ,
    output logic [N_CH-1:0] sq_out
`endif
);

    localparam int CH_W = ch_w(N_CH);

    logic [N_CH-1:0] w_cfg_hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no channel and are dropped
        assign w_cfg_hit[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        pixclk_gen_ch #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC),
            .LOCK_PULSES (LOCK_PULSES)
        ) u_ch (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .i_cfg_hit (w_cfg_hit[i]),
            .i_cfg_inc (cfg.cfg_inc),
            .i_sync    (cfg.sync_req),
            .o_ce      (ce[i]),
            .o_locked  (locked[i])
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
            ,
            .o_sq      (sq_out[i])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pixclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixclk_gen
// Description : Directed self-checking bench for pixclk_gen with three
//               channels (so an out-of-range channel number exists).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixclk_gen;
    import pixclk_gen_pkg::*;

    localparam int N_CH  = 3;
    localparam int ACC_W = 32;

    logic            refclk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] ce;
    logic [N_CH-1:0] locked;
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
    logic [N_CH-1:0] sq_out;
`endif

    int n_checks = 0;
    int n_err    = 0;

    pixclk_gen_if #(.N_CH(N_CH), .ACC_W(ACC_W)) cfg_bus ();

    pixclk_gen #(
        .N_CH        (N_CH),
        .ACC_W       (ACC_W),
        .DEFAULT_INC (32'h8000_0000),
        .LOCK_PULSES (16)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .cfg    (cfg_bus),
        .ce     (ce),
        .locked (locked)
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
        ,
        .sq_out (sq_out)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Forty edges after reset release with default divide-by-two on all channels
    task automatic run_after_reset(input string pfx);
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("%s_ce@%0d", pfx, k), ce, {3{k % 2 == 0}});
            chk($sformatf("%s_lock@%0d", pfx, k), locked, {3{k >= 32}});
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
            chk($sformatf("%s_sq@%0d", pfx, k), sq_out, {3{k % 2 == 1}});
`endif
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_inc  = '0;
        cfg_bus.sync_req = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ce", ce, 3'b000);
        chk("rst_lock", locked, 3'b000);
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
        chk("rst_sq", sq_out, 3'b000);
`endif
        @(negedge refclk);
        rst_n = 1'b1;

        // Scenario 1: edges 1..40
        run_after_reset("s1");

        // Scenario 2: ch1 -> 0x5555_5555 written on edge 41
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = 2'd1;
        cfg_bus.cfg_inc = 32'h5555_5555;
        tick();
        cfg_bus.cfg_we  = 1'b0;
        chk("s2_ce@41", ce, 3'b000);
        chk("s2_lock@41", locked, 3'b101);
        for (int k = 42; k <= 100; k++) begin
            tick();
            chk($sformatf("s2_ce@%0d", k), ce,
                {k % 2 == 0, (k >= 43) && ((k - 43) % 3 == 0), k % 2 == 0});
            chk($sformatf("s2_lock@%0d", k), locked, {1'b1, k >= 88, 1'b1});
        end

        // Scenario 3: ch0 idled on edge 101
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = 2'd0;
        cfg_bus.cfg_inc = 32'h0;
        tick();
        cfg_bus.cfg_we  = 1'b0;
        chk("s3_ce@101", ce, 3'b000);
        chk("s3_lock@101", locked, 3'b110);
        for (int k = 102; k <= 1101; k++) begin
            tick();
            chk($sformatf("s3_ce@%0d", k), ce,
                {k % 2 == 0, (k - 43) % 3 == 0, 1'b0});
            chk($sformatf("s3_lock@%0d", k), locked, 3'b110);
        end

        // Scenario 4: ch0 and ch1 -> 0x4000_0000 on different edges, then align
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = 2'd0;
        cfg_bus.cfg_inc = 32'h4000_0000;
        tick();
        cfg_bus.cfg_ch  = 2'd1;
        tick();
        cfg_bus.cfg_we  = 1'b0;
        repeat (80) tick();
        chk("s4_lock_pre", locked, 3'b111);
        cfg_bus.sync_req = 1'b1;
        tick();
        cfg_bus.sync_req = 1'b0;
        chk("s4_ce@s", ce, 3'b000);
        chk("s4_lock@s", locked, 3'b111);
        for (int d = 1; d <= 12; d++) begin
            tick();
            chk($sformatf("s4_ce@s+%0d", d), ce, {d % 2 == 0, d % 4 == 0, d % 4 == 0});
            chk($sformatf("s4_lock@s+%0d", d), locked, 3'b111);
        end

        // Scenario 5: write ch0 -> 0x2000_0000 together with sync, then bad channel
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = 2'd0;
        cfg_bus.cfg_inc  = 32'h2000_0000;
        cfg_bus.sync_req = 1'b1;
        tick();
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.sync_req = 1'b0;
        chk("s5_ce@s2", ce, 3'b000);
        chk("s5_lock@s2", locked, 3'b110);
        for (int d = 1; d <= 40; d++) begin
            tick();
            chk($sformatf("s5_ce@s2+%0d", d), ce, {d % 2 == 0, d % 4 == 0, d % 8 == 0});
            chk($sformatf("s5_lock@s2+%0d", d), locked, 3'b110);
            if (d == 16) begin
                cfg_bus.cfg_we  = 1'b1;
                cfg_bus.cfg_ch  = 2'd3;
                cfg_bus.cfg_inc = 32'h0;
            end
            if (d == 17) begin
                cfg_bus.cfg_we = 1'b0;
            end
        end

        // Scenario 6: asynchronous reset while all strobes are high
        chk("s6_ce_pre", ce, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_ce_async", ce, 3'b000);
        chk("s6_lock_async", locked, 3'b000);
`ifdef PIXCLK_GEN_SQUARE_OUT_EN
        chk("s6_sq_async", sq_out, 3'b000);
`endif
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        run_after_reset("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
